// File: rtl/ext_trig_run_ctrl.sv
// rtl/ext_trig_run_ctrl.sv - external-trigger run/arm/deadtime sequencer with accept/reject statistics
// Reject counters are built only when EXT_TRIG_REJECT_CNT_EN is defined; otherwise they read 0.
module ext_trig_run_ctrl #(
    parameter int CNT_W  = 32,
    parameter int DEAD_W = 16,
    parameter int TO_W   = 24
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              trig_edge,
    input  logic              busy,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic [DEAD_W-1:0] cfg_dead_cycles,
    input  logic [CNT_W-1:0]  cfg_max_trigs,
    input  logic [TO_W-1:0]   cfg_busy_timeout,
    output logic              accept,
    output logic              running,
    output logic [CNT_W-1:0]  trig_count,
    output logic [CNT_W-1:0]  rej_busy_count,
    output logic [CNT_W-1:0]  rej_dead_count,
    output logic              run_done,
    output logic              busy_timeout_err,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        RUN     = 3'd2,
        DEAD    = 3'd3,
        END_RUN = 3'd4
    } runStateT;

    localparam logic [CNT_W-1:0]  cntOne  = CNT_W'(1);
    localparam logic [DEAD_W-1:0] deadOne = DEAD_W'(1);
    localparam logic [TO_W-1:0]   toOne   = TO_W'(1);

    runStateT          curState;
    logic [DEAD_W-1:0] deadCnt;
    logic [TO_W-1:0]   toCnt;
    logic [CNT_W-1:0]  nextCount;
    logic              budgetHit;

    assign nextCount = trig_count + cntOne;
    assign budgetHit = (cfg_max_trigs != '0) && (nextCount == cfg_max_trigs);
    assign state     = curState;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            curState         <= IDLE;
            accept           <= 1'b0;
            running          <= 1'b0;
            trig_count       <= '0;
            run_done         <= 1'b0;
            busy_timeout_err <= 1'b0;
            deadCnt          <= '0;
            toCnt            <= '0;
        end else begin
            accept   <= 1'b0;
            run_done <= 1'b0;
            case (curState)
                IDLE: begin
                    if (start_req && !stop_req) begin
                        curState         <= ARM;
                        running          <= 1'b1;
                        trig_count       <= '0;
                        busy_timeout_err <= 1'b0;
                        toCnt            <= cfg_busy_timeout;
                    end
                end
                ARM: begin
                    if (stop_req) begin
                        curState <= IDLE;
                        running  <= 1'b0;
                    end else if (!busy) begin
                        curState <= RUN;
                    end else if ((cfg_busy_timeout != '0) && (toCnt <= toOne)) begin
                        curState         <= IDLE;
                        running          <= 1'b0;
                        busy_timeout_err <= 1'b1;
                    end else if (toCnt != '0) begin
                        toCnt <= toCnt - toOne;
                    end
                end
                RUN: begin
                    // A stop in the same cycle as a trigger wins; the trigger is dropped silently.
                    if (stop_req) begin
                        curState <= END_RUN;
                        running  <= 1'b0;
                        run_done <= 1'b1;
                    end else if (trig_edge && !busy) begin
                        accept     <= 1'b1;
                        trig_count <= nextCount;
                        if (budgetHit) begin
                            curState <= END_RUN;
                            running  <= 1'b0;
                            run_done <= 1'b1;
                        end else if (cfg_dead_cycles != '0) begin
                            curState <= DEAD;
                            deadCnt  <= cfg_dead_cycles;
                        end
                    end
                end
                DEAD: begin
                    if (stop_req) begin
                        curState <= END_RUN;
                        running  <= 1'b0;
                        run_done <= 1'b1;
                    end else if (deadCnt <= deadOne) begin
                        curState <= RUN;
                    end else begin
                        deadCnt <= deadCnt - deadOne;
                    end
                end
                END_RUN: begin
                    curState <= IDLE;
                end
                default: begin
                    curState <= IDLE;
                    running  <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXT_TRIG_REJECT_CNT_EN
    localparam logic [CNT_W-1:0] cntMax = {CNT_W{1'b1}};

    logic runStart;
    logic busyRej;
    logic deadRej;

    assign runStart = (curState == IDLE) && start_req && !stop_req;
    assign busyRej  = (curState == RUN) && trig_edge && busy && !stop_req;
    assign deadRej  = (curState == DEAD) && trig_edge && !stop_req;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rej_busy_count <= '0;
            rej_dead_count <= '0;
        end else if (runStart) begin
            rej_busy_count <= '0;
            rej_dead_count <= '0;
        end else begin
            if (busyRej && (rej_busy_count != cntMax)) begin
                rej_busy_count <= rej_busy_count + cntOne;
            end
            if (deadRej && (rej_dead_count != cntMax)) begin
                rej_dead_count <= rej_dead_count + cntOne;
            end
        end
    end
`else
    assign rej_busy_count = '0;
    assign rej_dead_count = '0;
`endif

endmodule

// File: tb/tb_ext_trig_run_ctrl.sv
// tb/tb_ext_trig_run_ctrl.sv - self-checking bench for ext_trig_run_ctrl against a timestamp-based run model
module tb_ext_trig_run_ctrl;

    localparam int CNT_W   = 4;
    localparam int DEAD_W  = 16;
    localparam int TO_W    = 24;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int SAT_MAX = CNT_MOD - 1;

`ifdef EXT_TRIG_REJECT_CNT_EN
    localparam bit REJ_EN = 1'b1;
`else
    localparam bit REJ_EN = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_ACT  = 2;
    localparam int P_END  = 4;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              trig_edge = 1'b0;
    logic              busy = 1'b0;
    logic              start_req = 1'b0;
    logic              stop_req = 1'b0;
    logic [DEAD_W-1:0] cfg_dead_cycles = '0;
    logic [CNT_W-1:0]  cfg_max_trigs = '0;
    logic [TO_W-1:0]   cfg_busy_timeout = '0;
    logic              accept;
    logic              running;
    logic [CNT_W-1:0]  trig_count;
    logic [CNT_W-1:0]  rej_busy_count;
    logic [CNT_W-1:0]  rej_dead_count;
    logic              run_done;
    logic              busy_timeout_err;
    logic [2:0]        state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int mPhase, mArmStart, mNext, mCount, mRejB, mRejD;
    bit mAcc, mDone, mErr;

    logic [18:0] dutVec;
    assign dutVec = {accept, running, run_done, busy_timeout_err, state,
                     trig_count, rej_busy_count, rej_dead_count};

    always #5 clock = ~clock;

    ext_trig_run_ctrl #(.CNT_W(CNT_W), .DEAD_W(DEAD_W), .TO_W(TO_W)) dut (
        .clock(clock),
        .resetn(resetn),
        .trig_edge(trig_edge),
        .busy(busy),
        .start_req(start_req),
        .stop_req(stop_req),
        .cfg_dead_cycles(cfg_dead_cycles),
        .cfg_max_trigs(cfg_max_trigs),
        .cfg_busy_timeout(cfg_busy_timeout),
        .accept(accept),
        .running(running),
        .trig_count(trig_count),
        .rej_busy_count(rej_busy_count),
        .rej_dead_count(rej_dead_count),
        .run_done(run_done),
        .busy_timeout_err(busy_timeout_err),
        .state(state)
    );

    task automatic modelReset();
        mPhase = P_IDLE; mArmStart = 0; mNext = 0; mCount = 0;
        mRejB = 0; mRejD = 0; mAcc = 0; mDone = 0; mErr = 0;
    endtask

    // Deadtime and ARM timeout are tracked as absolute cycle numbers, not countdowns.
    task automatic modelStep();
        int x;
        x = cyc;
        mAcc = 0;
        mDone = 0;
        case (mPhase)
            P_IDLE: if (start_req && !stop_req) begin
                mPhase = P_ARM; mArmStart = x + 1; mCount = 0; mRejB = 0; mRejD = 0; mErr = 0;
            end
            P_ARM: begin
                if (stop_req) mPhase = P_IDLE;
                else if (!busy) begin mPhase = P_ACT; mNext = x + 1; end
                else if (cfg_busy_timeout != 0 && (x - mArmStart + 1) >= int'(cfg_busy_timeout)) begin
                    mErr = 1; mPhase = P_IDLE;
                end
            end
            P_ACT: begin
                if (stop_req) begin mPhase = P_END; mDone = 1; end
                else if (trig_edge) begin
                    if (x < mNext) mRejD = (mRejD < SAT_MAX) ? mRejD + 1 : SAT_MAX;
                    else if (busy) mRejB = (mRejB < SAT_MAX) ? mRejB + 1 : SAT_MAX;
                    else begin
                        mAcc = 1;
                        mCount = (mCount + 1) % CNT_MOD;
                        if (cfg_max_trigs != 0 && mCount == int'(cfg_max_trigs)) begin
                            mPhase = P_END; mDone = 1;
                        end else mNext = x + 1 + int'(cfg_dead_cycles);
                    end
                end
            end
            default: mPhase = P_IDLE;
        endcase
    endtask

    function automatic logic [18:0] expVec();
        int st;
        logic [3:0] rb, rd;
        case (mPhase)
            P_IDLE:  st = 0;
            P_ARM:   st = 1;
            P_END:   st = 4;
            default: st = (cyc < mNext) ? 3 : 2;
        endcase
        rb = REJ_EN ? 4'(mRejB) : 4'd0;
        rd = REJ_EN ? 4'(mRejD) : 4'd0;
        return {mAcc, (mPhase == P_ARM || mPhase == P_ACT), mDone, mErr, 3'(st), 4'(mCount), rb, rd};
    endfunction

    task automatic tick();
        @(posedge clock);
        if (!resetn) modelReset();
        else modelStep();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (dutVec !== 19'd0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=0", dutVec);
        end
        checks++;
        if (state !== 3'd0) begin
            failures++; $display("FAIL reset_state got=%0d exp=0", state);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (dutVec !== expVec()) begin
            failures++; $display("FAIL reset_release got=%h exp=%h", dutVec, expVec());
        end
    endtask

    task automatic test_basic_run();
        int base;
        int accQ[$];
        cfg_dead_cycles = 16'd4; cfg_max_trigs = 4'd0; cfg_busy_timeout = '0; busy = 1'b0;
        start_req = 1'b1; base = cyc;
        tick();
        start_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            int r;
            r = cyc - base;
            trig_edge = (r == 10 || r == 12 || r == 15);
            tick();
            trig_edge = 1'b0;
            if (accept) accQ.push_back(cyc - base);
            checks++;
            if (dutVec !== expVec()) begin
                failures++; $display("FAIL basic_cycle r=%0d got=%h exp=%h", cyc - base, dutVec, expVec());
            end
        end
        checks++;
        if (accQ.size() != 2 || accQ[0] != 11 || accQ[1] != 16) begin
            failures++; $display("FAIL basic_accept_times got_n=%0d first=%0d exp=2 accepts at 11,16",
                                 accQ.size(), (accQ.size() > 0) ? accQ[0] : -1);
        end
        checks++;
        if (trig_count !== 4'd2) begin
            failures++; $display("FAIL basic_trig_count got=%0d exp=2", trig_count);
        end
        checks++;
        if (rej_dead_count !== (REJ_EN ? 4'd1 : 4'd0)) begin
            failures++; $display("FAIL basic_rej_dead got=%0d exp=%0d", rej_dead_count, REJ_EN ? 1 : 0);
        end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        checks++;
        if (run_done !== 1'b1 || state !== 3'd4) begin
            failures++; $display("FAIL basic_stop_end got done=%0b state=%0d exp done=1 state=4", run_done, state);
        end
        tick();
        checks++;
        if (state !== 3'd0 || trig_count !== 4'd2 || running !== 1'b0) begin
            failures++; $display("FAIL basic_idle_hold got state=%0d cnt=%0d run=%0b exp 0/2/0", state, trig_count, running);
        end
    endtask

    task automatic test_budget();
        int accN, doneN, thirdCyc, doneCyc;
        accN = 0; doneN = 0; thirdCyc = -1; doneCyc = -2;
        cfg_dead_cycles = '0; cfg_max_trigs = 4'd3; busy = 1'b0;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 2; j++) begin
                trig_edge = (j == 0);
                tick();
                trig_edge = 1'b0;
                if (accept) begin accN++; if (accN == 3) thirdCyc = cyc; end
                if (run_done) begin doneN++; doneCyc = cyc; end
            end
        end
        checks++;
        if (accN != 3) begin
            failures++; $display("FAIL budget_accepts got=%0d exp=3", accN);
        end
        checks++;
        if (doneN != 1 || doneCyc != thirdCyc) begin
            failures++; $display("FAIL budget_run_done got n=%0d at=%0d exp n=1 at=%0d", doneN, doneCyc, thirdCyc);
        end
        checks++;
        if (state !== 3'd0 || trig_count !== 4'd3 || running !== 1'b0) begin
            failures++; $display("FAIL budget_final got state=%0d cnt=%0d run=%0b exp 0/3/0", state, trig_count, running);
        end
    endtask

    task automatic test_busy_timeout();
        int n;
        bit sawDone;
        n = 0; sawDone = 0;
        cfg_dead_cycles = '0; cfg_max_trigs = '0; cfg_busy_timeout = 24'd8; busy = 1'b1;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        while (state == 3'd1 && n < 50) begin
            n++;
            tick();
            if (run_done) sawDone = 1;
        end
        checks++;
        if (n != 8) begin
            failures++; $display("FAIL timeout_arm_cycles got=%0d exp=8", n);
        end
        checks++;
        if (busy_timeout_err !== 1'b1 || state !== 3'd0 || sawDone) begin
            failures++; $display("FAIL timeout_flag got err=%0b state=%0d done=%0b exp 1/0/0", busy_timeout_err, state, sawDone);
        end
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
        tick();
        busy = 1'b0;
        tick();
        checks++;
        if (state !== 3'd2 || busy_timeout_err !== 1'b0) begin
            failures++; $display("FAIL timeout_recover got state=%0d err=%0b exp 2/0", state, busy_timeout_err);
        end
    endtask

    task automatic test_simultaneous();
        checks++;
        if (state !== 3'd2) begin
            failures++; $display("FAIL sim_pre_run got state=%0d exp=2", state);
        end
        stop_req = 1'b1; trig_edge = 1'b1;
        tick();
        stop_req = 1'b0; trig_edge = 1'b0;
        checks++;
        if (accept !== 1'b0 || trig_count !== 4'd0 || run_done !== 1'b1 || state !== 3'd4) begin
            failures++; $display("FAIL sim_stop_trig got acc=%0b cnt=%0d done=%0b state=%0d exp 0/0/1/4",
                                 accept, trig_count, run_done, state);
        end
        tick();
        checks++;
        if (state !== 3'd0 || run_done !== 1'b0) begin
            failures++; $display("FAIL sim_back_idle got state=%0d done=%0b exp 0/0", state, run_done);
        end
        start_req = 1'b1; stop_req = 1'b1;
        tick();
        start_req = 1'b0; stop_req = 1'b0;
        checks++;
        if (state !== 3'd0 || running !== 1'b0) begin
            failures++; $display("FAIL sim_start_stop got state=%0d run=%0b exp 0/0", state, running);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if (mPhase == P_IDLE && $urandom_range(0, 7) == 0) begin
                cfg_dead_cycles  = 16'($urandom_range(0, 4));
                cfg_max_trigs    = 4'($urandom_range(0, 5));
                cfg_busy_timeout = 24'($urandom_range(0, 6));
            end
            start_req = ($urandom_range(0, 9) == 0);
            stop_req  = ($urandom_range(0, 39) == 0);
            trig_edge = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) busy = ~busy;
            tick();
            checks++;
            if (dutVec !== expVec()) begin
                failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dutVec, expVec());
            end
        end
        start_req = 1'b0; trig_edge = 1'b0; busy = 1'b0; stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 3'd0) begin
            failures++; $display("FAIL random_drain got state=%0d exp=0", state);
        end
    endtask

    task automatic test_reject_saturation();
        cfg_dead_cycles = 16'd3; cfg_max_trigs = '0; cfg_busy_timeout = '0; busy = 1'b0;
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
        busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            trig_edge = 1'b1;
            tick();
            trig_edge = 1'b0;
            tick();
        end
        checks++;
        if (rej_busy_count !== (REJ_EN ? 4'd15 : 4'd0) || state !== 3'd2 || trig_count !== 4'd0) begin
            failures++; $display("FAIL sat_rej_busy got=%0d state=%0d cnt=%0d exp %0d/2/0",
                                 rej_busy_count, state, trig_count, REJ_EN ? 15 : 0);
        end
        busy = 1'b0; trig_edge = 1'b1;
        tick();
        trig_edge = 1'b0;
        checks++;
        if (accept !== 1'b1 || state !== 3'd3) begin
            failures++; $display("FAIL sat_enter_dead got acc=%0b state=%0d exp 1/3", accept, state);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (dutVec !== 19'd0) begin
            failures++; $display("FAIL async_reset got=%h exp=0", dutVec);
        end
        #10 resetn = 1'b1;
        modelReset();
        tick();
        checks++;
        if (dutVec !== expVec()) begin
            failures++; $display("FAIL post_reset got=%h exp=%h", dutVec, expVec());
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_budget();
        test_busy_timeout();
        test_simultaneous();
        test_random();
        test_reject_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
